// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: circular FIFO of (pc, inst) with epoch-based stale drop.
// Optional zero-latency empty-queue bypass enabled by defining INST_QUEUE_BYPASS_EN.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  output logic                     cur_epoch,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_epoch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high.
  // in_ready depends only on occupancy and reset, never on out_ready or in_valid.

  logic [63:0]    mem [DEPTH];
  logic [PW-1:0]  rd;
  logic [PW-1:0]  wr;
  logic           epoch_match;
  logic           byp;
  logic           enq;
  logic           pop;
  logic           not_empty;

  assign epoch_match = (in_epoch == cur_epoch);
  assign not_empty   = (count != '0);
  assign in_ready    = !reset && (count < DEPTH_C);

`ifdef INST_QUEUE_BYPASS_EN
  assign byp = !not_empty && in_valid && in_ready && epoch_match && !flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_inst  = '0;
    if (not_empty) begin
      out_valid = !flush;
      out_pc    = mem[rd][63:32];
      out_inst  = mem[rd][31:0];
    end else if (byp) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
  end

  // A bypassed response consumed by decode in the same cycle is never written.
  assign enq = in_valid && in_ready && !flush && epoch_match && !(byp && out_ready);
  assign pop = out_valid && out_ready && not_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      cur_epoch <= 1'b0;
    end else if (flush) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      cur_epoch <= ~cur_epoch;
    end else begin
      if (enq) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr] <= {in_pc, in_inst};
  end

endmodule
